// File: rtl/bram_dump_pkg.sv
// bram_dump_pkg
//   Shared types and constants for the BRAM dump reader slice.
//   dump_state_t : sweep controller states (IDLE, RUN, DRAIN, DONE)
//   SKID_DEPTH   : capacity of the output skid buffer; it also bounds the
//                  number of words the controller may have outstanding
package bram_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_dump_skid.sv
// bram_dump_skid
//   Two-entry {addr,data} FIFO. It is built as a shift pair so that the head
//   word always sits in entry 0 and drives the outputs straight from
//   registers.
//   Ports:
//     clk, reset         clock, synchronous active-low reset (empties buffer)
//     push, push_addr,   write one {addr,data} word
//     push_data
//     pop                remove the head word (ignored when empty)
//     head_addr,         head word
//     head_data
//     full, empty, count occupancy status
import bram_dump_pkg::*;

module bram_dump_skid #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic          v0_r, v1_r;
  logic [AW-1:0] a0_r, a1_r;
  logic [DW-1:0] d0_r, d1_r;
  logic          pop_s;

  // a pop on an empty buffer is meaningless and is dropped
  always_comb begin
    pop_s = pop && v0_r;
  end

  // entry storage: push fills the lowest free slot, pop shifts entry 1 down
  always_ff @(posedge clk) begin
    if (!reset) begin
      v0_r <= 1'b0;
      v1_r <= 1'b0;
      a0_r <= '0;
      a1_r <= '0;
      d0_r <= '0;
      d1_r <= '0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          if (!v0_r) begin
            v0_r <= 1'b1;
            a0_r <= push_addr;
            d0_r <= push_data;
          end else begin
            v1_r <= 1'b1;
            a1_r <= push_addr;
            d1_r <= push_data;
          end
        end
        2'b01: begin
          a0_r <= a1_r;
          d0_r <= d1_r;
          v0_r <= v1_r;
          v1_r <= 1'b0;
        end
        2'b11: begin
          if (v1_r) begin
            a0_r <= a1_r;
            d0_r <= d1_r;
            a1_r <= push_addr;
            d1_r <= push_data;
          end else begin
            a0_r <= push_addr;
            d0_r <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_addr = a0_r;
  assign head_data = d0_r;
  assign full      = v1_r;
  assign empty     = !v0_r;
  // entry 1 is only ever valid while entry 0 is valid
  assign count     = {v1_r, v0_r & !v1_r};

endmodule

// File: rtl/bram_dump_reader.sv
// bram_dump_reader
//   Sweeps every word of a dual-port BRAM once per start request and streams
//   {addr,data} out over valid/ready. The RAM has a one-cycle registered read.
//   Optional feature macro: BRAM_DUMP_CHECKSUM_EN adds a running XOR checksum
//   of all handshaked words (port 'checksum').
//   Ports:
//     clk, reset          clock, synchronous active-low reset
//     start               begin a sweep (ignored unless idle)
//     raddr / rdata       RAM read address (registered) / RAM read data
//     out_valid/out_ready output handshake
//     out_addr/out_data   address and contents of the presented word
//     busy                sweep in progress
//     done                one-cycle pulse after the final handshake
//     checksum            XOR of handshaked words (macro only)
import bram_dump_pkg::*;

module bram_dump_reader #(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 128,
  parameter int ADDR_W    = $clog2(DEPTH_MEM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [WID_MEM-1:0] out_data,
  output logic               busy,
  output logic               done
`ifdef BRAM_DUMP_CHECKSUM_EN
  ,
  output logic [WID_MEM-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  dump_state_t       state_r;
  logic [ADDR_W-1:0] raddr_r;
  logic [ADDR_W-1:0] cap_addr_r;
  logic              inflight_r;
  logic              armed_r;
  logic              busy_r;
  logic              done_r;

  logic              pop_s;
  logic              issue_s;
  logic              start_ok_s;
  logic              drained_s;
  logic [2:0]        occ_eff_s;
  logic              full_s;
  logic              empty_s;
  logic [1:0]        count_s;

  bram_dump_skid #(
    .AW (ADDR_W),
    .DW (WID_MEM)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_r),
    .push_addr (cap_addr_r),
    .push_data (rdata),
    .pop       (pop_s),
    .head_addr (out_addr),
    .head_data (out_data),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // issue/accept decisions; occupancy counts the word leaving this cycle as
  // already gone so a steady ready stream sustains one word per cycle
  always_comb begin
    pop_s      = !empty_s && out_ready;
    occ_eff_s  = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (state_r == RUN) begin
      issue_s = (occ_eff_s < 3'(SKID_DEPTH));
    end else begin
      issue_s = 1'b0;
    end
    // armed_r masks a start that arrives on the reset-release edge
    start_ok_s = start && armed_r && (state_r == IDLE);
    // buffer will be empty after this edge and nothing is still in the RAM
    drained_s  = !inflight_r && (empty_s || (!full_s && pop_s));
  end

  // sweep FSM, address counter and in-flight tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      raddr_r    <= '0;
      cap_addr_r <= '0;
      inflight_r <= 1'b0;
      armed_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      armed_r    <= 1'b1;
      inflight_r <= issue_s;
      done_r     <= 1'b0;
      if (issue_s) begin
        cap_addr_r <= raddr_r;
      end
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r <= RUN;
            raddr_r <= '0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          // raddr holds the pending address until it is issued; the last
          // address stays on the bus afterwards instead of wrapping
          if (issue_s) begin
            if (raddr_r == LAST_ADDR) begin
              state_r <= DRAIN;
            end else begin
              raddr_r <= raddr_r + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drained_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign raddr     = raddr_r;
  assign out_valid = !empty_s;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [WID_MEM-1:0] checksum_r;

  // running XOR of accepted words, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_r <= '0;
    end else if (start_ok_s) begin
      checksum_r <= '0;
    end else if (pop_s) begin
      checksum_r <= checksum_r ^ out_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_bram_dump_reader.sv
module tb_bram_dump_reader;

  localparam int WID   = 16;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  raddr;
  logic [WID-1:0] rdata = '0;
  logic           out_valid;
  logic [AW-1:0]  out_addr;
  logic [WID-1:0] out_data;
  logic           busy;
  logic           done;
`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [WID-1:0] checksum;
`endif

  logic [WID-1:0] ram [DEPTH];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  bit             mon_en = 1'b0;
  int             exp_idx = 0;
  int             hs_cnt = 0;
  int             done_cnt = 0;
  bit             done_due = 1'b0;
  bit             stall_prev = 1'b0;
  int             start_cyc = 0;
  int             done_cyc = 0;
  logic [AW-1:0]  last_addr = '0;
  logic [WID-1:0] last_data = '0;
  logic [WID-1:0] model_xor = '0;

  bram_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef BRAM_DUMP_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read
  always @(posedge clk) rdata <= ram[raddr];

  function automatic logic [WID-1:0] exp_word(input int idx);
    return 16'hA500 + 16'(idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_idx    = 0;
    hs_cnt     = 0;
    done_cnt   = 0;
    done_due   = 1'b0;
    stall_prev = 1'b0;
    model_xor  = '0;
    mon_en     = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    model_clear();
  endtask

  // compare process: stream must be 0..DEPTH-1 in order with RAM contents,
  // held while stalled, and done exactly one cycle after the last handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_idx >= DEPTH) begin
          check("extra_word", 32'(exp_idx), 32'(DEPTH - 1));
        end else begin
          check("out_addr", 32'(out_addr), 32'(exp_idx));
          check("out_data", 32'(out_data), 32'(exp_word(exp_idx)));
        end
      end else if (stall_prev) begin
        check("valid_held", 32'(out_valid), 32'd1);
      end
      check("done", 32'(done), 32'(done_due));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
`ifdef BRAM_DUMP_CHECKSUM_EN
      check("checksum_run", 32'(checksum), 32'(model_xor));
`endif
      done_due = 1'b0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_addr = out_addr;
        last_data = out_data;
        model_xor = model_xor ^ exp_word(exp_idx);
        exp_idx++;
        if (hs_cnt == DEPTH) done_due = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
    end
  end

  // mode 0: ready=1, 1: random ready, 2: ready low 20 cycles,
  // 3: ignored starts at words 10 and 60, 5: stop at word 50
  task automatic run(input int mode, input int limit);
    bit p10 = 1'b0;
    bit p60 = 1'b0;
    bit stopped = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (done_cnt > 0) begin
        stopped = 1'b1;
        break;
      end
      if (mode == 5 && hs_cnt >= 50) begin
        stopped = 1'b1;
        break;
      end
      if (mode == 2 && c == 20) begin
        check("stall_raddr", 32'(raddr), 32'd2);
        check("stall_head_addr", 32'(out_addr), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
      end
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (c >= 20);
        default: out_ready = 1'b1;
      endcase
      start = 1'b0;
      if (mode == 3 && hs_cnt == 10 && !p10) begin
        start = 1'b1;
        p10 = 1'b1;
      end
      if (mode == 3 && hs_cnt == 60 && !p60) begin
        start = 1'b1;
        p60 = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    check("sweep_within_bound", 32'(stopped), 32'd1);
  endtask

  task automatic post_sweep();
    out_ready = 1'b1;
    repeat (4) tick();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("word_total", 32'(hs_cnt), 32'(DEPTH));
    check("last_addr", 32'(last_addr), 32'd127);
    check("last_data", 32'(last_data), 32'hA57F);
    check("raddr_no_wrap", 32'(raddr), 32'd127);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'hA500 + 16'(i);

    // test 1: reset, latency, full-rate sweep
    reset = 1'b0;
    tick();
    tick();
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    do_start();
    check("lat_n1_raddr", 32'(raddr), 32'd0);
    check("lat_n1_busy", 32'(busy), 32'd1);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_n3_valid", 32'(out_valid), 32'd1);
    check("lat_n3_data", 32'(out_data), 32'hA500);
    run(0, 400);
    check("sweep_cycles", 32'(done_cyc - start_cyc), 32'(DEPTH + 2));
    post_sweep();
`ifdef BRAM_DUMP_CHECKSUM_EN
    check("checksum_final", 32'(checksum), 32'h0000);
`endif

    // test 2: random backpressure
    do_start();
`ifdef BRAM_DUMP_CHECKSUM_EN
    check("checksum_cleared", 32'(checksum), 32'h0000);
`endif
    run(1, 2000);
    post_sweep();

    // test 3: ready held low for 20 cycles after start
    out_ready = 1'b0;
    do_start();
    run(2, 600);
    post_sweep();

    // test 4: starts during the sweep are ignored
    out_ready = 1'b1;
    do_start();
    run(3, 600);
    post_sweep();

    // test 5: reset mid-sweep, start on release edge ignored, then full sweep
    do_start();
    run(5, 600);
    reset  = 1'b0;
    mon_en = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_raddr", 32'(raddr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("release_start_ignored", 32'(busy), 32'd0);
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    do_start();
    check("restart_busy", 32'(busy), 32'd1);
    run(0, 400);
    post_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
